// File: rtl/data_io_pkg.sv
// Shared width default and Gray-code conversion helpers for the data_io Gray counter.
package data_io_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [DEFAULT_WIDTH-1:0] word_t;

    function automatic word_t bin2gray(input word_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above its position.
    function automatic word_t gray2bin(input word_t g);
        word_t b;
        b[DEFAULT_WIDTH-1] = g[DEFAULT_WIDTH-1];
        for (int i = DEFAULT_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/data_io_if.sv
// Bundles the count enable and the Gray-coded output word of data_io.
interface data_io_if
    import data_io_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic clk
);
    logic             enable;
    logic [WIDTH-1:0] valuegray;

    modport master (input clk, output enable, input  valuegray);
    modport slave  (input clk, input  enable, output valuegray);
endinterface

// File: rtl/data_io_gray_encode.sv
// Purely combinational binary-to-Gray converter.
module gray_encode #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_bin,
    output logic [WIDTH-1:0] o_gray
);
    assign o_gray = i_bin ^ (i_bin >> 1);
endmodule

// File: rtl/data_io.sv
// Free-running Gray-code counter: a binary counter whose next value is Gray-encoded
// and registered, so the output word changes by exactly one bit per enabled clock.
module data_io
    import data_io_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    output logic [WIDTH-1:0] valuegray,
    input  logic             clk,
    input  logic             reset,
    input  logic             enable
);
    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] w_bin_nxt;
    logic [WIDTH-1:0] w_gray_nxt;

    assign w_bin_nxt = r_bin + WIDTH'(1);

    // Encoding the next count lets valuegray come straight from a flop, glitch-free.
    gray_encode #(.WIDTH(WIDTH)) u_gray_encode (
        .i_bin  (w_bin_nxt),
        .o_gray (w_gray_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bin     <= '0;
            valuegray <= '0;
        end else if (enable) begin
            r_bin     <= w_bin_nxt;
            valuegray <= w_gray_nxt;
        end
    end

    // Checked on the upcoming step rather than via $past, so a reset pulse between
    // edges cannot be mistaken for a multi-bit transition.
    a_single_bit_step : assert property (
        @(posedge clk) disable iff (!reset)
        enable |-> $onehot(valuegray ^ w_gray_nxt)
    );

endmodule

// File: tb/tb_data_io.sv
// Bench for data_io: vector tables, hand-written reset sequences and a long randomized
// run, all checked against a reflected-Gray reference table and a counting model.
module tb_data_io;
    import data_io_pkg::*;

    localparam int W = 8;
    localparam int N = 1 << W;

    logic clk;
    logic reset;

    data_io_if #(.WIDTH(W)) bus (.clk(clk));

    data_io #(.WIDTH(W)) dut (
        .valuegray (bus.valuegray),
        .clk       (clk),
        .reset     (reset),
        .enable    (bus.enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          en;
        logic [7:0]  exp;
    } vec_t;

    vec_t        vecs[17];
    logic [7:0]  gref[N];
    int          seen[N];
    int          errors;
    int          checks;
    int          cnt;
    int          distinct;
    logic [7:0]  prev;
    bit          en_r;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference Gray sequence built by reflection, independent of any XOR formula.
    task automatic build_gray_table();
        gref[0] = 8'h00;
        for (int k = 0; k < W; k++) begin
            for (int i = 0; i < (1 << k); i++) begin
                gref[(1 << k) + i] = gref[(1 << k) - 1 - i] | 8'(1 << k);
            end
        end
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.enable = vecs[i].en;
            @(negedge clk);
            check($sformatf("vec[%0d]", i), bus.valuegray, vecs[i].exp);
        end
    endtask

    // Async reset pulse starting 2 ns after a negedge, released 11 ns later between edges.
    task automatic mid_reset();
        #2 reset = 1'b0;
        #1 check("async_clear", bus.valuegray, 8'h00);
        #9 check("reset_hold", bus.valuegray, 8'h00);
        #1 reset = 1'b1;
        cnt = 0;
        #1 check("post_release", bus.valuegray, 8'h00);
        @(negedge clk);
    endtask

    // One model step: advance the reference count when enabled, then compare.
    task automatic model_step(input bit en, input string tag);
        prev       = bus.valuegray;
        bus.enable = en;
        @(negedge clk);
        if (en) cnt++;
        check(tag, bus.valuegray, gref[cnt % N]);
        check_int({tag, "_bitdiff"}, $countones(bus.valuegray ^ prev), en ? 1 : 0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cnt    = 0;
        build_gray_table();

        vecs[0]  = '{1'b1, 8'h01};
        vecs[1]  = '{1'b1, 8'h03};
        vecs[2]  = '{1'b1, 8'h02};
        vecs[3]  = '{1'b1, 8'h06};
        vecs[4]  = '{1'b1, 8'h07};
        vecs[5]  = '{1'b1, 8'h05};
        vecs[6]  = '{1'b1, 8'h04};
        vecs[7]  = '{1'b1, 8'h0C};
        vecs[8]  = '{1'b1, 8'h03};
        vecs[9]  = '{1'b1, 8'h02};
        vecs[10] = '{1'b1, 8'h06};
        vecs[11] = '{1'b0, 8'h06};
        vecs[12] = '{1'b0, 8'h06};
        vecs[13] = '{1'b0, 8'h06};
        vecs[14] = '{1'b0, 8'h06};
        vecs[15] = '{1'b0, 8'h06};
        vecs[16] = '{1'b1, 8'h07};

        // Power-up: reset low for 11 ns with enable already high.
        reset      = 1'b0;
        bus.enable = 1'b1;
        #1  check("por_t1", bus.valuegray, 8'h00);
        #9  check("por_after_edge", bus.valuegray, 8'h00);
        #1  reset = 1'b1;
        #1  check("por_released", bus.valuegray, 8'h00);

        apply_vecs(0, 7);

        mid_reset();
        check("restart_first", bus.valuegray, 8'h01);
        apply_vecs(8, 16);

        // Full wrap from a fresh reset.
        mid_reset();
        check("wrap_start", bus.valuegray, 8'h01);
        for (int i = 0; i < N; i++) seen[i] = 0;
        seen[bus.valuegray]++;
        cnt = 1;
        for (int k = 2; k <= N; k++) begin
            bus.enable = 1'b1;
            @(negedge clk);
            cnt++;
            check($sformatf("wrap[%0d]", k), bus.valuegray, gref[cnt % N]);
            check_int($sformatf("wrap_bin[%0d]", k), int'(gray2bin(bus.valuegray)), cnt % N);
            seen[bus.valuegray]++;
            if (k == N - 1) check("wrap_top", bus.valuegray, 8'h80);
            if (k == N)     check("wrap_zero", bus.valuegray, 8'h00);
        end
        distinct = 0;
        for (int i = 0; i < N; i++) if (seen[i] != 0) distinct++;
        check_int("wrap_unique", distinct, N);

        // Long continuous run, about 7.8 wraps.
        for (int k = 0; k < 2000; k++) model_step(1'b1, "long");

        // Randomized enable pattern.
        for (int k = 0; k < 600; k++) begin
            en_r = 1'($urandom_range(0, 1));
            model_step(en_r, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
